// File: rtl/culsans_sim_ctrl.sv
// culsans_sim_ctrl: simulation-control block for multi-hart culsans benches.
// Divides the core clock down to an RTC tick, captures per-hart exit words,
// aggregates them into a registered done/fail/code result and runs an
// optional cycle watchdog that ends runaway simulations.
module culsans_sim_ctrl #(
   parameter int unsigned NumCh         = 2,
   parameter int unsigned ExitW         = 32,
   parameter int unsigned RtcHalf       = 1526,
   parameter int unsigned TimeoutCycles = 0,
   parameter bit          WaitAll       = 1'b1,
   localparam int unsigned ChW          = (NumCh > 1) ? $clog2(NumCh) : 1
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic [NumCh*ExitW-1:0] exit_i,
   output logic                   rtc_o,
   output logic [NumCh-1:0]       exited_o,
   output logic                   done_o,
   output logic                   fail_o,
   output logic                   timeout_o,
   output logic [ExitW-2:0]       code_o,
   output logic [ChW-1:0]         first_ch_o
);

   localparam int unsigned RtcW = (RtcHalf > 1) ? $clog2(RtcHalf) : 1;
   localparam logic [RtcW-1:0] RtcLast = RtcW'(RtcHalf - 1);
   localparam logic [31:0] WdLast = 32'(TimeoutCycles - 1);
   localparam bit WdEnable = (TimeoutCycles != 0);

   // RTC divider state
   logic [RtcW-1:0]  r_rtcCnt;
   logic             r_rtc;

   // Exit capture state
   logic [NumCh-1:0] r_exited;
   logic [ExitW-2:0] r_chCode [NumCh];
   logic [ChW-1:0]   r_firstCh;

   // Result and watchdog state
   logic [31:0]      r_wdCnt;
   logic             r_done;
   logic             r_fail;
   logic             r_timeout;
   logic [ExitW-2:0] r_codeOut;

   // Combinational helpers
   logic [NumCh-1:0] w_capture;
   logic [NumCh-1:0] w_exitedNext;
   logic [ChW-1:0]   w_firstIdx;
   logic [ExitW-2:0] w_aggCode;
   logic             w_cond;
   logic             w_condNext;
   logic             w_wdHit;

   // RTC counter wraps at RtcHalf-1 and toggles the RTC output on that edge
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_rtcCnt <= '0;
         r_rtc    <= 1'b0;
      end else if (r_rtcCnt == RtcLast) begin
         r_rtcCnt <= '0;
         r_rtc    <= ~r_rtc;
      end else begin
         r_rtcCnt <= r_rtcCnt + 1'b1;
      end
   end

   // Channels that newly exit on this edge and the lowest-index one among them
   always_comb begin
      w_capture  = '0;
      w_firstIdx = '0;
      for (int c = 0; c < NumCh; c++) begin
         w_capture[c] = exit_i[c*ExitW] & ~r_exited[c];
      end
      for (int c = NumCh - 1; c >= 0; c--) begin
         if (w_capture[c]) begin
            w_firstIdx = ChW'(c);
         end
      end
      w_exitedNext = r_exited | w_capture;
   end

   // Completion condition on the current mask and on the mask after this edge
   always_comb begin
      if (WaitAll) begin
         w_cond     = &r_exited;
         w_condNext = &w_exitedNext;
      end else begin
         w_cond     = |r_exited;
         w_condNext = |w_exitedNext;
      end
      w_wdHit = WdEnable && (r_wdCnt == WdLast);
   end

   // Aggregate code: lowest nonzero code when waiting for all, else the first exiter's code
   always_comb begin
      w_aggCode = '0;
      if (WaitAll) begin
         for (int c = NumCh - 1; c >= 0; c--) begin
            if (r_chCode[c] != '0) begin
               w_aggCode = r_chCode[c];
            end
         end
      end else begin
         for (int c = 0; c < NumCh; c++) begin
            if (ChW'(c) == r_firstCh) begin
               w_aggCode = r_chCode[c];
            end
         end
      end
   end

   // Sticky per-channel capture of the exit flag, return code and first exiter
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_exited  <= '0;
         r_firstCh <= '0;
         for (int c = 0; c < NumCh; c++) begin
            r_chCode[c] <= '0;
         end
      end else begin
         r_exited <= w_exitedNext;
         for (int c = 0; c < NumCh; c++) begin
            if (w_capture[c]) begin
               r_chCode[c] <= exit_i[c*ExitW+1 +: ExitW-1];
            end
         end
         if ((r_exited == '0) && (w_capture != '0)) begin
            r_firstCh <= w_firstIdx;
         end
      end
   end

   // Registered result; a completing exit on the watchdog edge beats the timeout
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_wdCnt   <= '0;
         r_done    <= 1'b0;
         r_fail    <= 1'b0;
         r_timeout <= 1'b0;
         r_codeOut <= '0;
      end else if (!r_done) begin
         r_wdCnt <= r_wdCnt + 32'd1;
         if (w_cond) begin
            r_done    <= 1'b1;
            r_timeout <= 1'b0;
            r_codeOut <= w_aggCode;
            r_fail    <= (w_aggCode != '0);
         end else if (w_wdHit && !w_condNext) begin
            r_done    <= 1'b1;
            r_timeout <= 1'b1;
            r_codeOut <= w_aggCode;
            r_fail    <= 1'b1;
         end
      end
   end

   assign rtc_o      = r_rtc;
   assign exited_o   = r_exited;
   assign done_o     = r_done;
   assign fail_o     = r_fail;
   assign timeout_o  = r_timeout;
   assign code_o     = r_codeOut;
   assign first_ch_o = r_firstCh;

endmodule

// File: tb/tb_culsans_sim_ctrl.sv
// tb_culsans_sim_ctrl: directed self-checking bench for culsans_sim_ctrl.
// Four instances share clock and reset: A (wait-all), B (wait-any),
// C (wait-any, watchdog 100) and D (wait-all, watchdog 100).
// Edge numbering: edge 1 is the first rising clk edge after reset release.
module tb_culsans_sim_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [63:0] exA = '0, exB = '0, exC = '0, exD = '0;

   logic        rtcA, rtcB, rtcC, rtcD;
   logic [1:0]  exitedA, exitedB, exitedC, exitedD;
   logic        doneA, doneB, doneC, doneD;
   logic        failA, failB, failC, failD;
   logic        toA, toB, toC, toD;
   logic [30:0] codeA, codeB, codeC, codeD;
   logic [0:0]  firstA, firstB, firstC, firstD;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   culsans_sim_ctrl #(.NumCh(2), .ExitW(32), .RtcHalf(4), .TimeoutCycles(0), .WaitAll(1'b1)) dutA (
      .clk_i(clk), .rst_ni(rst_n), .exit_i(exA), .rtc_o(rtcA), .exited_o(exitedA), .done_o(doneA),
      .fail_o(failA), .timeout_o(toA), .code_o(codeA), .first_ch_o(firstA));

   culsans_sim_ctrl #(.NumCh(2), .ExitW(32), .RtcHalf(4), .TimeoutCycles(0), .WaitAll(1'b0)) dutB (
      .clk_i(clk), .rst_ni(rst_n), .exit_i(exB), .rtc_o(rtcB), .exited_o(exitedB), .done_o(doneB),
      .fail_o(failB), .timeout_o(toB), .code_o(codeB), .first_ch_o(firstB));

   culsans_sim_ctrl #(.NumCh(2), .ExitW(32), .RtcHalf(4), .TimeoutCycles(100), .WaitAll(1'b0)) dutC (
      .clk_i(clk), .rst_ni(rst_n), .exit_i(exC), .rtc_o(rtcC), .exited_o(exitedC), .done_o(doneC),
      .fail_o(failC), .timeout_o(toC), .code_o(codeC), .first_ch_o(firstC));

   culsans_sim_ctrl #(.NumCh(2), .ExitW(32), .RtcHalf(4), .TimeoutCycles(100), .WaitAll(1'b1)) dutD (
      .clk_i(clk), .rst_ni(rst_n), .exit_i(exD), .rtc_o(rtcD), .exited_o(exitedD), .done_o(doneD),
      .fail_o(failD), .timeout_o(toD), .code_o(codeD), .first_ch_o(firstD));

   // Hold reset for two edges with all exit inputs cleared, release on a falling edge
   task automatic applyReset();
      rst_n = 1'b0;
      exA = '0; exB = '0; exC = '0; exD = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Advance n rising edges and settle just after the last one
   task automatic stepEdges(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #2;
      checks++;
      if ({rtcA, exitedA, doneA, failA, toA, codeA, firstA} !== '0) begin
         failures++;
         $display("[TB] FAIL reset_A got=%0h exp=0", {rtcA, exitedA, doneA, failA, toA, codeA, firstA});
      end
      checks++;
      if ({rtcC, exitedC, doneC, failC, toC, codeC, firstC} !== '0) begin
         failures++;
         $display("[TB] FAIL reset_C got=%0h exp=0", {rtcC, exitedC, doneC, failC, toC, codeC, firstC});
      end
   endtask

   task automatic test_rtc();
      int expRtc;
      applyReset();
      for (int e = 1; e <= 16; e++) begin
         stepEdges(1);
         expRtc = (e / 4) % 2;
         checks++;
         if (rtcA !== expRtc[0]) begin
            failures++;
            $display("[TB] FAIL rtc_edge%0d got=%0b exp=%0b", e, rtcA, expRtc[0]);
         end
      end
      checks++;
      if (doneA !== 1'b0) begin
         failures++;
         $display("[TB] FAIL rtc_no_done got=%0b exp=0", doneA);
      end
   endtask

   task automatic test_wait_all();
      applyReset();
      stepEdges(9);
      exA[32 +: 32] = 32'h7;
      stepEdges(1);
      checks++;
      if (exitedA !== 2'b10 || doneA !== 1'b0) begin
         failures++;
         $display("[TB] FAIL wall_ch1 got exited=%0b done=%0b exp exited=10 done=0", exitedA, doneA);
      end
      exA[32 +: 32] = 32'h0;
      stepEdges(8);
      exA[0 +: 32] = 32'h1;
      stepEdges(1);
      checks++;
      if (exitedA !== 2'b11 || doneA !== 1'b0) begin
         failures++;
         $display("[TB] FAIL wall_ch0 got exited=%0b done=%0b exp exited=11 done=0", exitedA, doneA);
      end
      stepEdges(1);
      checks++;
      if ({doneA, failA, toA, codeA, firstA} !== {1'b1, 1'b1, 1'b0, 31'h3, 1'b1}) begin
         failures++;
         $display("[TB] FAIL wall_done got done=%0b fail=%0b to=%0b code=%0h first=%0d exp 1 1 0 3 1",
                  doneA, failA, toA, codeA, firstA);
      end
      exA = 64'hFFFF_FFFF_FFFF_FFFF;
      stepEdges(5);
      checks++;
      if ({doneA, failA, codeA, firstA} !== {1'b1, 1'b1, 31'h3, 1'b1}) begin
         failures++;
         $display("[TB] FAIL wall_frozen got done=%0b fail=%0b code=%0h first=%0d exp 1 1 3 1",
                  doneA, failA, codeA, firstA);
      end
   endtask

   task automatic test_wait_any();
      applyReset();
      stepEdges(4);
      exB = {32'h5, 32'h1};
      stepEdges(1);
      checks++;
      if (exitedB !== 2'b11 || doneB !== 1'b0 || firstB !== 1'b0) begin
         failures++;
         $display("[TB] FAIL wany_cap got exited=%0b done=%0b first=%0d exp 11 0 0", exitedB, doneB, firstB);
      end
      stepEdges(1);
      checks++;
      if ({doneB, failB, toB, codeB} !== {1'b1, 1'b0, 1'b0, 31'h0}) begin
         failures++;
         $display("[TB] FAIL wany_done got done=%0b fail=%0b to=%0b code=%0h exp 1 0 0 0", doneB, failB, toB, codeB);
      end
      exB[32 +: 32] = 32'hFF;
      stepEdges(4);
      checks++;
      if ({doneB, failB, codeB, firstB} !== {1'b1, 1'b0, 31'h0, 1'b0}) begin
         failures++;
         $display("[TB] FAIL wany_ignore got done=%0b fail=%0b code=%0h first=%0d exp 1 0 0 0",
                  doneB, failB, codeB, firstB);
      end
      applyReset();
      stepEdges(2);
      exB[32 +: 32] = 32'h9;
      stepEdges(2);
      checks++;
      if ({exitedB, doneB, failB, codeB, firstB} !== {2'b10, 1'b1, 1'b1, 31'h4, 1'b1}) begin
         failures++;
         $display("[TB] FAIL wany_ch1 got exited=%0b done=%0b fail=%0b code=%0h first=%0d exp 10 1 1 4 1",
                  exitedB, doneB, failB, codeB, firstB);
      end
   endtask

   task automatic test_timeout();
      applyReset();
      stepEdges(49);
      exD[32 +: 32] = 32'hB;
      stepEdges(50);
      checks++;
      if (doneC !== 1'b0 || toC !== 1'b0 || doneD !== 1'b0) begin
         failures++;
         $display("[TB] FAIL to_early got doneC=%0b toC=%0b doneD=%0b exp 0 0 0", doneC, toC, doneD);
      end
      stepEdges(1);
      checks++;
      if ({toC, doneC, failC, codeC} !== {1'b1, 1'b1, 1'b1, 31'h0}) begin
         failures++;
         $display("[TB] FAIL to_C got to=%0b done=%0b fail=%0b code=%0h exp 1 1 1 0", toC, doneC, failC, codeC);
      end
      checks++;
      if ({exitedD, toD, doneD, failD, codeD} !== {2'b10, 1'b1, 1'b1, 1'b1, 31'h5}) begin
         failures++;
         $display("[TB] FAIL to_D got exited=%0b to=%0b done=%0b fail=%0b code=%0h exp 10 1 1 1 5",
                  exitedD, toD, doneD, failD, codeD);
      end
      exC[0 +: 32] = 32'h3;
      stepEdges(50);
      checks++;
      if ({toC, doneC, failC, codeC} !== {1'b1, 1'b1, 1'b1, 31'h0}) begin
         failures++;
         $display("[TB] FAIL to_stable got to=%0b done=%0b fail=%0b code=%0h exp 1 1 1 0", toC, doneC, failC, codeC);
      end
   endtask

   task automatic test_timeout_race();
      applyReset();
      stepEdges(99);
      exC[0 +: 32] = 32'h1;
      stepEdges(1);
      checks++;
      if (exitedC !== 2'b01 || doneC !== 1'b0 || toC !== 1'b0) begin
         failures++;
         $display("[TB] FAIL race_edge got exited=%0b done=%0b to=%0b exp 01 0 0", exitedC, doneC, toC);
      end
      stepEdges(1);
      checks++;
      if ({doneC, toC, failC, codeC} !== {1'b1, 1'b0, 1'b0, 31'h0}) begin
         failures++;
         $display("[TB] FAIL race_done got done=%0b to=%0b fail=%0b code=%0h exp 1 0 0 0", doneC, toC, failC, codeC);
      end
      stepEdges(10);
      checks++;
      if (toC !== 1'b0 || doneC !== 1'b1) begin
         failures++;
         $display("[TB] FAIL race_hold got to=%0b done=%0b exp 0 1", toC, doneC);
      end
   endtask

   task automatic test_async_reset();
      applyReset();
      stepEdges(1);
      exB[32 +: 32] = 32'h9;
      stepEdges(6);
      checks++;
      if (doneB !== 1'b1 || rtcB !== 1'b1) begin
         failures++;
         $display("[TB] FAIL ares_pre got done=%0b rtc=%0b exp 1 1", doneB, rtcB);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({rtcB, exitedB, doneB, failB, toB, codeB, firstB} !== '0) begin
         failures++;
         $display("[TB] FAIL ares_clear got=%0h exp=0", {rtcB, exitedB, doneB, failB, toB, codeB, firstB});
      end
      exB = '0;
      @(negedge clk);
      rst_n = 1'b1;
      stepEdges(1);
      exB[0 +: 32] = 32'h3;
      stepEdges(1);
      checks++;
      if (exitedB !== 2'b01 || doneB !== 1'b0) begin
         failures++;
         $display("[TB] FAIL ares_cap got exited=%0b done=%0b exp 01 0", exitedB, doneB);
      end
      stepEdges(1);
      checks++;
      if ({doneB, failB, toB, codeB, firstB} !== {1'b1, 1'b1, 1'b0, 31'h1, 1'b0}) begin
         failures++;
         $display("[TB] FAIL ares_redo got done=%0b fail=%0b to=%0b code=%0h first=%0d exp 1 1 0 1 0",
                  doneB, failB, toB, codeB, firstB);
      end
   endtask

   initial begin
      test_reset();
      test_rtc();
      test_wait_all();
      test_wait_any();
      test_timeout();
      test_timeout_race();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
